// File: rtl/router_pkg.sv
// Shared constants, helper function and stored-word type for the router packet FIFO.
package router_pkg;

    // Header byte layout: [WIDTH-1:HDR_LEN_LSB] payload length, [HDR_ADDR_W-1:0] destination.
    localparam int HDR_LEN_LSB = 2;
    localparam int HDR_ADDR_W  = 2;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Ceiling log2; usable in constant expressions. Returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Stored word at the default width: header flag above the data byte.
    typedef struct packed {
        logic                 hdr;
        logic [DEF_WIDTH-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: synchronous write, addressed read.
module router_fifo_mem #(
    parameter int DW = 9,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [2**AW];

    // Store the incoming word at the write address.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read word is registered by the owner of the read pointer.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO: stores a header flag beside each word,
// tracks packet boundaries on the read side and reports occupancy and error pulses.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_MARGIN = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  lfd_state,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  read_enb,
    output logic [WIDTH-1:0]      data_out,
    output logic                  data_out_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [clog2(DEPTH):0] count,
    output logic                  pkt_active,
    output logic                  pkt_done,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = clog2(DEPTH);
    // Length field sits above the destination address bits of the header.
    localparam int LEN_LSB = (HDR_LEN_LSB > HDR_ADDR_W) ? HDR_LEN_LSB : HDR_ADDR_W;
    localparam int LW      = WIDTH - LEN_LSB;

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [LW:0] CNT_ONE  = (LW+1)'(1);

    typedef struct packed {
        logic             hdr;
        logic [WIDTH-1:0] data;
    } word_t;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic [LW:0]      r_pkt_cnt;
    logic             r_pkt_active;
    logic             r_pkt_done;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;
    word_t            w_wr_word;
    word_t            w_rd_word;
    logic [LW-1:0]    w_hdr_len;

    // Flags come only from registered pointers/count, never from the enables.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_wr_acc = write_enb && !w_full;
    assign w_rd_acc = read_enb && !w_empty;

    assign w_wr_word.hdr  = lfd_state;
    assign w_wr_word.data = data_in;
    assign w_hdr_len      = w_rd_word.data[WIDTH-1:LEN_LSB];

    router_fifo_mem #(
        .DW ($bits(word_t)),
        .AW (AW)
    ) u_mem (
        .i_clk     (clock),
        .i_wr_en   (w_wr_acc && !soft_reset),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_word),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_word)
    );

    // Pointer and occupancy bookkeeping; a flush returns everything to empty.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (soft_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + PTR_ONE;
            end else if (!w_wr_acc && w_rd_acc) begin
                r_count <= r_count - PTR_ONE;
            end
        end
    end

    // Registered read data, its valid strobe and the error pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (soft_reset) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            r_overflow   <= write_enb && w_full;
            r_underflow  <= read_enb && w_empty;
            if (w_rd_acc) begin
                r_data_out <= w_rd_word.data;
            end
        end
    end

    // Packet tracking: a header loads length+1 (payload plus parity), later words count down.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pkt_cnt    <= '0;
            r_pkt_active <= 1'b0;
            r_pkt_done   <= 1'b0;
        end else if (soft_reset) begin
            r_pkt_cnt    <= '0;
            r_pkt_active <= 1'b0;
            r_pkt_done   <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            if (w_rd_acc) begin
                if (w_rd_word.hdr) begin
                    // A header always restarts the count, even mid-packet.
                    r_pkt_cnt    <= {1'b0, w_hdr_len} + CNT_ONE;
                    r_pkt_active <= 1'b1;
                end else if (r_pkt_active) begin
                    if (r_pkt_cnt == CNT_ONE) begin
                        r_pkt_cnt    <= '0;
                        r_pkt_active <= 1'b0;
                        r_pkt_done   <= 1'b1;
                    end else begin
                        r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
                    end
                end
            end
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_valid;
    assign empty          = w_empty;
    assign full           = w_full;
    assign almost_full    = (r_count >= AF_LEVEL);
    assign count          = r_count;
    assign pkt_active     = r_pkt_active;
    assign pkt_done       = r_pkt_done;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule
